instr_decode_reg: RTL and testbench

INSTR_DECODE_REG -- requirements
Module: instr_decode_reg

---
 rtl/mips_pkg.sv | 20 ++
 rtl/instr_decode_reg_sign_extend.sv | 10 +
 rtl/instr_decode_reg.sv | 79 +++++++
 tb/tb_instr_decode_reg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode constants, instruction field positions/widths and immediate-class helper.
package mips_pkg;
  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int TARGET_W = 26;
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;
  function automatic logic is_logical(input logic [OP_W-1:0] op);
    return op == OP_ANDI || op == OP_ORI || op == OP_XORI;
  endfunction
endpackage

// File: rtl/instr_decode_reg_sign_extend.sv
// SignExtendUnit: replicates the MSB of a FROM-bit value up to TO bits.
module SignExtendUnit #(
  parameter int FROM = 16,
  parameter int TO   = 32
) (
  input  logic [FROM-1:0] din,
  output logic [TO-1:0]   dout
);
  assign dout = {{(TO-FROM){din[FROM-1]}}, din};
endmodule

// File: rtl/instr_decode_reg.sv
// instr_decode_reg: two-entry skid-buffered MIPS decode register with stall counter.
module instr_decode_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [25:0]       out_target,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc4,
  output logic [15:0]       stall_cnt
);
  logic              h_v, s_v, acc, xfer;
  logic [DATA_W-1:0] h_instr, h_pc4, s_instr, s_pc4, in_pc4, sext;
  logic [IMM_W-1:0]  imm;
  // pc+4 is stored rather than pc so that out_pc4 reads 0 out of reset
  assign in_pc4   = in_pc + DATA_W'(4);
  assign in_ready = ~s_v;
  assign acc      = in_valid & in_ready;
  assign xfer     = h_v & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h_v     <= 1'b0;
      s_v     <= 1'b0;
      h_instr <= '0;
      h_pc4   <= '0;
      s_instr <= '0;
      s_pc4   <= '0;
    end else if (flush) begin
      h_v <= 1'b0;
      s_v <= 1'b0;
    end else if (xfer && s_v) begin
      h_instr <= s_instr;
      h_pc4   <= s_pc4;
      s_v     <= 1'b0;
    end else if (acc && (xfer || !h_v)) begin
      h_instr <= in_instr;
      h_pc4   <= in_pc4;
      h_v     <= 1'b1;
    end else if (acc) begin
      s_instr <= in_instr;
      s_pc4   <= in_pc4;
      s_v     <= 1'b1;
    end else if (xfer)
      h_v <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst)
      stall_cnt <= '0;
    else if (h_v && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  SignExtendUnit #(.FROM(IMM_W), .TO(DATA_W)) u_sext (.din(imm), .dout(sext));
  assign imm        = h_instr[IMM_W-1:0];
  assign out_valid  = h_v;
  assign out_pc4    = h_pc4;
  assign out_opcode = h_instr[OP_LSB +: OP_W];
  assign out_rs     = h_instr[RS_LSB +: REG_W];
  assign out_rt     = h_instr[RT_LSB +: REG_W];
  assign out_rd     = h_instr[RD_LSB +: REG_W];
  assign out_shamt  = h_instr[SHAMT_LSB +: REG_W];
  assign out_funct  = h_instr[FUNCT_LSB +: FUNCT_W];
  assign out_target = h_instr[TARGET_W-1:0];
  assign out_imm    = out_opcode == OP_LUI    ? {imm, {(DATA_W-IMM_W){1'b0}}} :
                      is_logical(out_opcode)  ? DATA_W'(imm) : sext;
endmodule

// File: tb/tb_instr_decode_reg.sv
// tb_instr_decode_reg: randomized + directed scoreboard bench for instr_decode_reg.
module tb_instr_decode_reg;
  logic        clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] in_instr = 0, in_pc = 0, out_imm, out_pc4;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [25:0] out_target;
  logic [15:0] stall_cnt;
  int          errors = 0, checks = 0;
  logic [127:0] q[$];
  logic [15:0] m_stall = 0;
  instr_decode_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_target(out_target),
    .out_imm(out_imm), .out_pc4(out_pc4), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] exp_of(input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] op, imm16, imm;
    op    = ins >> 26;
    imm16 = ins & 32'hFFFF;
    if (op == 32'h0F) imm = imm16 << 16;
    else if (op >= 32'h0C && op <= 32'h0E) imm = imm16;
    else imm = imm16 >= 32'd32768 ? imm16 + 32'hFFFF0000 : imm16;
    return {6'(op), 5'(ins >> 21), 5'(ins >> 16), 5'(ins >> 11), 5'(ins >> 6), 6'(ins),
            26'(ins), imm, pc + 32'd4};
  endfunction
  always @(negedge clk) begin : mon
    int n;
    if (rst) begin
      q.delete();
      m_stall = 0;
    end else begin
      n = q.size();
      chk("out_valid", out_valid, n != 0);
      chk("in_ready", in_ready, n < 2);
      chk("stall_cnt", stall_cnt, m_stall);
      if (n != 0 && !out_ready && m_stall != 16'hFFFF) m_stall++;
      if (!flush && n != 0 && out_ready) begin
        chk("head", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_target,
                     out_imm, out_pc4}, q[0]);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && n < 2) q.push_back(exp_of(in_instr, in_pc));
    end
  end
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask
  initial begin
    logic [5:0] op;
    #1 rst = 1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc4", out_pc4, 0);
    chk("rst_fields", {out_opcode, out_rs, out_rt, out_rd, out_target}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 32'h2008FFFF, 32'h100, 1, 0);
    cyc(0, 0, 0, 1, 0);
    #1;
    chk("addi_valid", out_valid, 1);
    chk("addi_rt", out_rt, 8);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_pc4", out_pc4, 32'h104);
    cyc(1, 32'h3508FFFF, 32'h200, 1, 0);
    cyc(0, 0, 0, 1, 0);
    #1 chk("ori_imm", out_imm, 32'h0000FFFF);
    cyc(1, 32'h3C081234, 32'hFFFFFFFC, 1, 0);
    cyc(0, 0, 0, 1, 0);
    #1;
    chk("lui_imm", out_imm, 32'h12340000);
    chk("pc4_wrap", out_pc4, 32'h0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h8C430010, 32'h300, 0, 0);
    cyc(1, 32'h3128ABCD, 32'h304, 0, 0);
    cyc(1, 32'h014B4820, 32'h308, 0, 0);
    #1 chk("skid_full_ready", in_ready, 0);
    repeat (3) cyc(1, 32'h014B4820, 32'h308, 0, 0);
    #1 chk("held_rt", out_rt, 5'd3);
    cyc(1, 32'h014B4820, 32'h308, 1, 0);
    #1 chk("stall_count", stall_cnt, 5);
    cyc(1, 32'h014B4820, 32'h308, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h2402AAAA, 32'h400, 0, 0);
    cyc(1, 32'h2403BBBB, 32'h404, 0, 0);
    cyc(1, 32'h2404CCCC, 32'h408, 1, 1);
    cyc(0, 0, 0, 1, 0);
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    cyc(1, 32'h2405DDDD, 32'h40C, 1, 1);
    cyc(0, 0, 0, 1, 0);
    #1 chk("flush_drop", out_valid, 0);
    repeat (400) begin
      case ($urandom_range(0, 7))
        0: op = 6'h0F;
        1: op = 6'h0C;
        2: op = 6'h0D;
        3: op = 6'h0E;
        4: op = 6'h08;
        5: op = 6'h23;
        6: op = 6'h00;
        default: op = 6'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, {op, 26'($urandom)}, $urandom & 32'hFFFFFFFC,
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    cyc(1, 32'h8FBF0018, 32'h500, 0, 0);
    cyc(1, 32'h27BDFFE8, 32'h504, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #1 rst = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_stall", stall_cnt, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_data", {out_opcode, out_imm, out_pc4}, 0);
    @(posedge clk);
    #1;
    rst = 0; in_valid = 1; in_instr = 32'h2009FFFE; in_pc = 32'h600; out_ready = 1;
    cyc(0, 0, 0, 1, 0);
    #1 chk("post_rst_accept", {out_valid, out_imm}, {1'b1, 32'hFFFFFFFE});
    repeat (3) cyc(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
